instruction_fetch: RTL



---
 rtl/instruction_fetch.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - program-memory fetch and 1/2-byte instruction assembly for the Jimmy ISA.
// Optional undefined-opcode trap and STOP state enabled by ILLEGAL_OPCODE_CHECK_EN.
module instruction_fetch #(
    parameter logic [7:0] RESET_PC = 8'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [7:0]  address_bus,
    input  logic [7:0]  data_bus,
    output logic [15:0] instr_word,
    output logic        instr_len,
    output logic [7:0]  instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [7:0]  branch_target,
    output logic        illegal_op
);

`ifdef ILLEGAL_OPCODE_CHECK_EN
    typedef enum logic [1:0] {FETCH1, FETCH2, HOLD, STOP} state_t;
`else
    typedef enum logic [1:0] {FETCH1, FETCH2, HOLD} state_t;
`endif

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [15:0] word_q, word_d;
    logic        len_q, len_d;
    logic [7:0]  ipc_q, ipc_d;
    logic        valid_q, valid_d;
    logic        illegal_q, illegal_d;
    logic        opcode_illegal;

    function automatic logic is_two_byte(input logic [7:0] b);
        return (b[7:2] == 6'b100000) || (b[7:2] == 6'b100011) || (b[7:5] == 3'b101);
    endfunction

`ifdef ILLEGAL_OPCODE_CHECK_EN
    function automatic logic is_illegal(input logic [7:0] b);
        logic bad_branch;
        bad_branch = (b[7:5] == 3'b101) && (b != 8'hA8) && (b != 8'hB0) && (b != 8'hB4);
        return (b[7:4] == 4'b0001)
            || ((b[7:4] == 4'b0111) && (b != 8'h70))
            || (b[7:2] == 6'b100001)
            || (b[7:2] == 6'b100010)
            || (b[7:4] >= 4'b1101)
            || bad_branch;
    endfunction

    assign opcode_illegal = is_illegal(data_bus);
`else
    assign opcode_illegal = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        word_d    = word_q;
        len_d     = len_q;
        ipc_d     = ipc_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;

        case (state_q)
            FETCH1: begin
                opcode_d = data_bus;
                ipc_d    = pc_q;
                pc_d     = pc_q + 8'd1;
                // An undefined opcode is never given an operand byte.
                if (!opcode_illegal && is_two_byte(data_bus)) begin
                    state_d = FETCH2;
                end else begin
                    word_d    = {data_bus, 8'h00};
                    len_d     = 1'b0;
                    valid_d   = 1'b1;
                    illegal_d = opcode_illegal;
                    state_d   = HOLD;
                end
            end
            FETCH2: begin
                pc_d    = pc_q + 8'd1;
                word_d  = {opcode_q, data_bus};
                len_d   = 1'b1;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (instr_ready) begin
                    valid_d   = 1'b0;
                    illegal_d = 1'b0;
`ifdef ILLEGAL_OPCODE_CHECK_EN
                    state_d   = illegal_q ? STOP : FETCH1;
`else
                    state_d   = FETCH1;
`endif
                end
            end
`ifdef ILLEGAL_OPCODE_CHECK_EN
            STOP: begin
                state_d = STOP;
            end
`endif
            default: begin
                state_d = FETCH1;
            end
        endcase

        // Redirect wins over everything; a coincident handshake has already been honoured above.
        if (branch_taken) begin
            pc_d      = branch_target;
            state_d   = FETCH1;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH1;
            pc_q      <= RESET_PC;
            opcode_q  <= 8'h00;
            word_q    <= 16'h0000;
            len_q     <= 1'b0;
            ipc_q     <= 8'h00;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            word_q    <= word_d;
            len_q     <= len_d;
            ipc_q     <= ipc_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign address_bus = pc_q;
    assign instr_word  = word_q;
    assign instr_len   = len_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;
    assign illegal_op  = illegal_q;

endmodule
